// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the HH:MM:SS time-keeping / time-set slice.
//   mode_e    : controller mode, encoded as it appears on the mode output
//   bcd_t     : one 4-bit BCD digit
//   HR_MAX    : last valid hours value (BCD 23)
//   MIN_MAX   : last valid minutes value (BCD 59)
//   *_LSB     : bit offsets of each two-digit field in the 24-bit digit bus,
//               packed {hr_t,hr_o,min_t,min_o,sec_t,sec_o}
//   DAY_LAST  : 23:59:59, the last count before the day wraps
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_COMMIT  = 2'd3
  } mode_e;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0]  HR_MAX   = 8'h23;
  localparam logic [7:0]  MIN_MAX  = 8'h59;

  localparam int          HR_LSB   = 16;
  localparam int          MIN_LSB  = 8;
  localparam int          SEC_LSB  = 0;

  localparam logic [23:0] DAY_LAST = 24'h235959;

endpackage

// File: rtl/bcd2_wrap_inc.sv
// -----------------------------------------------------------------------------
// bcd2_wrap_inc
// Combinational two-digit BCD increment. Any value at or above MAX wraps to 00,
// so an out-of-range value captured from the counter still lands on a legal
// value. Neither output digit ever exceeds 9.
// Ports:
//   i_val  in  8  current value {tens, ones}, BCD
//   o_val  out 8  incremented value {tens, ones}, BCD
// -----------------------------------------------------------------------------
module bcd2_wrap_inc
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = HR_MAX
) (
  input  logic [7:0] i_val,
  output logic [7:0] o_val
);

  bcd_t w_tens;
  bcd_t w_ones;

  assign w_tens = i_val[7:4];
  assign w_ones = i_val[3:0];

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    o_val = 8'h00;
    if (i_val >= MAX) begin
      o_val = 8'h00;
    end else if (w_ones >= 4'd9) begin
      // Ones roll over; tens carry but never step past 9.
      o_val = {((w_tens >= 4'd9) ? 4'd0 : (w_tens + 4'd1)), 4'd0};
    end else begin
      o_val = {w_tens, (w_ones + 4'd1)};
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl
// Time-keeping and time-set controller for a six-digit BCD HH:MM:SS counter.
// Produces the 1 Hz count enable, the 23:59:59 -> 00:00:00 day wrap, runs the
// hours-then-minutes set sequence from debounced button pulses and drives the
// counter's load port and the display blink mask. All outputs are registered.
// Parameters:
//   TICK_DIV   clk cycles per second
//   TIMEOUT_S  idle seconds before a set state is abandoned
// Ports:
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-high reset
//   btn_mode    in   1  one-cycle pulse: advance mode
//   btn_inc     in   1  one-cycle pulse: increment selected field
//   cur_digits  in  24  counter value {hr,min,sec}, BCD
//   cnt_en      out  1  one-cycle counter increment enable
//   cnt_load    out  1  one-cycle counter load strobe
//   ld_digits   out 24  load value, same packing as cur_digits
//   blink_mask  out  3  [2]=blank hours, [1]=blank minutes, [0]=blank seconds
//   mode        out  2  0=RUN 1=SET_HR 2=SET_MIN 3=COMMIT
// -----------------------------------------------------------------------------
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] cur_digits,
  output logic        cnt_en,
  output logic        cnt_load,
  output logic [23:0] ld_digits,
  output logic [2:0]  blink_mask,
  output logic [1:0]  mode
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam int            TW         = $clog2(TIMEOUT_S + 1);
  localparam logic [PW-1:0] PRESC_TC   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_S);

  mode_e         r_state;
  logic [PW-1:0] r_presc;
  logic          r_phase;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_shadow_hr;
  logic [7:0]    r_shadow_min;
  logic          r_cnt_en;
  logic          r_cnt_load;
  logic [23:0]   r_ld_digits;
  logic [2:0]    r_blink_mask;

  mode_e         w_next_state;
  logic          w_tc;
  logic          w_phase_d;
  logic          w_press;
  logic          w_expire;
  logic          w_day_end;
  logic [7:0]    w_hr_inc;
  logic [7:0]    w_min_inc;
  logic          w_cnt_en_d;
  logic          w_cnt_load_d;
  logic [23:0]   w_ld_digits_d;
  logic [2:0]    w_blink_mask_d;

  assign w_tc      = (r_presc == PRESC_TC);
  assign w_phase_d = (w_tc || (r_presc == PRESC_HALF)) ? ~r_phase : r_phase;
  assign w_press   = btn_mode | btn_inc;
  // A press in the expiry cycle keeps the user in the set state.
  assign w_expire  = (r_tmo == TMO_LIMIT) && !w_press;
  assign w_day_end = (cur_digits == DAY_LAST);

  bcd2_wrap_inc #(.MAX(HR_MAX)) u_hr_inc (
    .i_val (r_shadow_hr),
    .o_val (w_hr_inc)
  );

  bcd2_wrap_inc #(.MAX(MIN_MAX)) u_min_inc (
    .i_val (r_shadow_min),
    .o_val (w_min_inc)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MODE_RUN;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (btn_mode outranks btn_inc and the timeout)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MODE_RUN:     if (btn_mode) w_next_state = MODE_SET_HR;
      MODE_SET_HR:  if (btn_mode) w_next_state = MODE_SET_MIN;
                    else if (w_expire) w_next_state = MODE_RUN;
      MODE_SET_MIN: if (btn_mode) w_next_state = MODE_COMMIT;
                    else if (w_expire) w_next_state = MODE_RUN;
      MODE_COMMIT:  w_next_state = MODE_RUN;
      default:      w_next_state = MODE_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic, computed one cycle ahead and registered below
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cnt_en_d     = 1'b0;
    w_cnt_load_d   = 1'b0;
    w_ld_digits_d  = '0;
    w_blink_mask_d = 3'b000;

    case (r_state)
      MODE_RUN: begin
        if (w_tc) begin
          // The day wrap is a load of zero rather than an increment.
          if (w_day_end) w_cnt_load_d = 1'b1;
          else           w_cnt_en_d   = 1'b1;
        end
      end
      MODE_COMMIT: begin
        w_cnt_load_d  = 1'b1;
        w_ld_digits_d = {r_shadow_hr, r_shadow_min, 8'h00};
      end
      default: ;
    endcase

    // Mask follows the state it will be shown alongside.
    case (w_next_state)
      MODE_SET_HR:  w_blink_mask_d = {w_phase_d, 2'b00};
      MODE_SET_MIN: w_blink_mask_d = {1'b0, w_phase_d, 1'b0};
      default:      w_blink_mask_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_en     <= 1'b0;
      r_cnt_load   <= 1'b0;
      r_ld_digits  <= '0;
      r_blink_mask <= 3'b000;
    end else begin
      r_cnt_en     <= w_cnt_en_d;
      r_cnt_load   <= w_cnt_load_d;
      r_ld_digits  <= w_ld_digits_d;
      r_blink_mask <= w_blink_mask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, blink phase, timeout counter, shadow fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc      <= '0;
      r_phase      <= 1'b0;
      r_tmo        <= '0;
      r_shadow_hr  <= 8'h00;
      r_shadow_min <= 8'h00;
    end else begin
      // Clearing in COMMIT makes the first tick land a full second after the load.
      if ((r_state == MODE_COMMIT) || w_tc) r_presc <= '0;
      else                                  r_presc <= r_presc + 1'b1;

      r_phase <= w_phase_d;

      case (r_state)
        MODE_SET_HR, MODE_SET_MIN: begin
          if (w_press)                          r_tmo <= '0;
          else if (w_tc && (r_tmo != TMO_LIMIT)) r_tmo <= r_tmo + 1'b1;
        end
        default: r_tmo <= '0;
      endcase

      case (r_state)
        MODE_RUN: begin
          if (btn_mode) begin
            r_shadow_hr  <= cur_digits[HR_LSB  +: 8];
            r_shadow_min <= cur_digits[MIN_LSB +: 8];
          end
        end
        MODE_SET_HR:  if (btn_inc && !btn_mode) r_shadow_hr  <= w_hr_inc;
        MODE_SET_MIN: if (btn_inc && !btn_mode) r_shadow_min <= w_min_inc;
        default: ;
      endcase
    end
  end

  assign cnt_en     = r_cnt_en;
  assign cnt_load   = r_cnt_load;
  assign ld_digits  = r_ld_digits;
  assign blink_mask = r_blink_mask;
  assign mode       = r_state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_ctrl
// Self-checking bench for clock_mode_ctrl with TICK_DIV=4, TIMEOUT_S=3.
// Expected load values are queued when the stimulus that causes them is driven
// and compared by a monitor when cnt_load appears. Scenario tasks check the
// remaining behaviour inline. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_clock_mode_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int TIMEOUT_S = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] cur_digits = 24'h000000;
  logic        cnt_en;
  logic        cnt_load;
  logic [23:0] ld_digits;
  logic [2:0]  blink_mask;
  logic [1:0]  mode;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_load_q[$];
  logic [23:0] mon_exp;
  logic        en_sticky = 1'b0;
  logic        load_sticky = 1'b0;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_digits (cur_digits),
    .cnt_en     (cnt_en),
    .cnt_load   (cnt_load),
    .ld_digits  (ld_digits),
    .blink_mask (blink_mask),
    .mode       (mode)
  );

  // Scoreboard monitor: every load strobe must match the oldest queued value.
  always @(negedge clk) begin
    if (!reset && cnt_load === 1'b1) begin
      checks++;
      if (exp_load_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: ld_digits=%06h, no load expected", ld_digits);
      end else begin
        mon_exp = exp_load_q.pop_front();
        if (ld_digits !== mon_exp) begin
          errors++;
          $display("FAIL load_value: ld_digits=%06h expected %06h", ld_digits, mon_exp);
        end
      end
      checks++;
      if (cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL load_en_overlap: cnt_en=%b expected 0 during cnt_load", cnt_en);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Independent BCD model: decimal arithmetic, modulo the field range.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int modulo);
    int n;
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    n = (n + 1) % modulo;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic cycle();
    @(negedge clk);
    en_sticky   = en_sticky | cnt_en;
    load_sticky = load_sticky | cnt_load;
  endtask

  task automatic pulse(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    cycle();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic check_mode(input string name, input logic [1:0] exp_mode);
    checks++;
    if (mode !== exp_mode) begin
      errors++;
      $display("FAIL %s: mode=%0d expected %0d", name, mode, exp_mode);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt_en, cnt_load, ld_digits, blink_mask, mode} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b load=%b ld=%06h blink=%b mode=%0d expected all 0",
               cnt_en, cnt_load, ld_digits, blink_mask, mode);
    end
    reset = 1'b0;
  endtask

  task automatic test_run_tick();
    logic exp_en;
    cur_digits = 24'h000000;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      exp_en = ((n % TICK_DIV) == 0);
      checks++;
      if ({cnt_load, cnt_en, blink_mask, mode} !== {1'b0, exp_en, 3'b000, 2'b00}) begin
        errors++;
        $display("FAIL run_tick[%0d]: load=%b en=%b blink=%b mode=%0d expected load=0 en=%b blink=000 mode=0",
                 n, cnt_load, cnt_en, blink_mask, mode, exp_en);
      end
    end
  endtask

  task automatic test_day_wrap();
    logic found = 1'b0;
    cur_digits = 24'h235959;
    exp_load_q.push_back(24'h000000);
    en_sticky = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (cnt_load === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL day_wrap_load: cnt_load seen=%b expected 1 within 8 cycles", found);
    end
    checks++;
    if (en_sticky !== 1'b0) begin
      errors++;
      $display("FAIL day_wrap_no_en: cnt_en seen=%b expected 0", en_sticky);
    end
    cur_digits = 24'h000000;
  endtask

  task automatic test_set_sequence();
    logic [7:0] exp_hr;
    logic [7:0] exp_min;
    int         k;
    cur_digits = 24'h094117;
    exp_hr  = cur_digits[23:16];
    exp_min = cur_digits[15:8];
    pulse(1'b1, 1'b0);
    check_mode("set_enter_hr", 2'd1);
    en_sticky   = 1'b0;
    load_sticky = 1'b0;
    for (int n = 0; n < 15; n++) begin
      pulse(1'b0, 1'b1);
      exp_hr = bcd_inc(exp_hr, 24);
      cycle();
    end
    check_mode("set_hr_hold", 2'd1);
    pulse(1'b1, 1'b0);
    check_mode("set_enter_min", 2'd2);
    for (int n = 0; n < 20; n++) begin
      pulse(1'b0, 1'b1);
      exp_min = bcd_inc(exp_min, 60);
      cycle();
    end
    check_mode("set_min_hold", 2'd2);
    checks++;
    if ({en_sticky, load_sticky} !== 2'b00) begin
      errors++;
      $display("FAIL set_frozen: en seen=%b load seen=%b expected 0 0", en_sticky, load_sticky);
    end
    exp_load_q.push_back({exp_hr, exp_min, 8'h00});
    pulse(1'b1, 1'b0);
    check_mode("set_commit", 2'd3);
    cycle();
    checks++;
    if ({cnt_load, mode} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL commit_load: load=%b mode=%0d expected load=1 mode=0", cnt_load, mode);
    end
    k = 0;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      if (cnt_en === 1'b1) begin
        k = n;
        break;
      end
    end
    checks++;
    if (k != TICK_DIV) begin
      errors++;
      $display("FAIL commit_first_en: cnt_en after %0d cycles expected %0d", k, TICK_DIV);
    end
  endtask

  task automatic test_timeout();
    int n_exit = 0;
    int n_en   = 0;
    cur_digits = 24'h120000;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check_mode("timeout_enter_min", 2'd2);
    en_sticky   = 1'b0;
    load_sticky = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (mode === 2'd0) begin
        n_exit = n;
        break;
      end
    end
    checks++;
    if (n_exit < 3 * TICK_DIV - 2 || n_exit > 3 * TICK_DIV + 1) begin
      errors++;
      $display("FAIL timeout_exit: left SET_MIN after %0d cycles expected 10..13", n_exit);
    end
    checks++;
    if ({en_sticky, load_sticky} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_quiet: en seen=%b load seen=%b expected 0 0", en_sticky, load_sticky);
    end
    for (int n = 1; n <= TICK_DIV + 1; n++) begin
      cycle();
      if (cnt_en === 1'b1) begin
        n_en = n;
        break;
      end
    end
    checks++;
    if (n_en == 0 || load_sticky !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resume: cnt_en after %0d cycles load seen=%b expected 1..%0d and 0",
               n_en, load_sticky, TICK_DIV);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    logic       other_bits = 1'b0;
    cur_digits = 24'h070000;
    pulse(1'b1, 1'b0);
    check_mode("simul_enter_hr", 2'd1);
    pulse(1'b1, 1'b1);
    check_mode("simul_mode_wins", 2'd2);
    for (int n = 0; n < 8; n++) begin
      cycle();
      v[n] = blink_mask[1];
      other_bits = other_bits | blink_mask[2] | blink_mask[0];
    end
    checks++;
    if (other_bits !== 1'b0) begin
      errors++;
      $display("FAIL blink_min_only: hour/second blink seen=%b expected 0", other_bits);
    end
    for (int n = 2; n < 8; n++) begin
      checks++;
      if (v[n] !== ~v[n-2]) begin
        errors++;
        $display("FAIL blink_period[%0d]: samples=%b expected toggle every 2 cycles", n, v);
      end
    end
    exp_load_q.push_back(24'h070000);
    pulse(1'b1, 1'b0);
    check_mode("simul_commit", 2'd3);
    cycle();
    checks++;
    if (cnt_load !== 1'b1) begin
      errors++;
      $display("FAIL simul_load: cnt_load=%b expected 1", cnt_load);
    end
  endtask

  task automatic test_reset_mid_set();
    cur_digits = 24'h101010;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check_mode("midreset_enter_min", 2'd2);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cnt_en, cnt_load, ld_digits, blink_mask, mode} !== 31'd0) begin
      errors++;
      $display("FAIL midreset_async: en=%b load=%b ld=%06h blink=%b mode=%0d expected all 0",
               cnt_en, cnt_load, ld_digits, blink_mask, mode);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    load_sticky = 1'b0;
    repeat (10) cycle();
    check_mode("midreset_run", 2'd0);
    checks++;
    if (load_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_load: load seen=%b expected 0", load_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_day_wrap();
    test_set_sequence();
    test_timeout();
    test_simultaneous();
    test_reset_mid_set();
    checks++;
    if (exp_load_q.size() != 0) begin
      errors++;
      $display("FAIL loads_outstanding: %0d expected loads never seen, expected 0",
               exp_load_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
